// File: rtl/imem_cmd_loader.sv
// imem_cmd_loader: byte-wide host command slave that loads a 32-bit
// instruction store and provides a registered fetch port for the core.
// Each word holds four bytes big-endian, so byte address 0 is instr[31:24].
// The core's reset is held active until start_signal is raised while idle.
// Optional build macro: LOADER_LOCK_EN. When defined, storage is locked
// against writes while the core runs.
module imem_cmd_loader #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cmd,
  input  logic              cmd_valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        data_in,
  output logic              cmd_done,
  output logic [7:0]        data_out,
  input  logic              start_signal,
  output logic              cpu_rst_n,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_instr
);

  localparam int          MEM_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);
  localparam logic [7:0]  CMD_RD   = 8'd1;
  localparam logic [7:0]  CMD_WR   = 8'd2;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        din_q;
  logic [7:0]        data_out_q;
  logic              cpu_rst_n_q;
  logic [31:0]       fetch_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Word indices are derived by shifting the full address so the range
  // checks see every address bit, including those above the store depth.
  logic [ADDR_W-1:0] cmd_word;
  logic [ADDR_W-1:0] fetch_word;
  logic              cmd_in_range;
  logic              fetch_in_range;
  logic [4:0]        lane_off;
  logic [7:0]        rd_byte;
  logic              wr_allow;
  logic              wr_en;

  assign cmd_word       = addr_q >> 2;
  assign fetch_word     = fetch_addr >> 2;
  assign cmd_in_range   = (cmd_word < DEPTH_L);
  assign fetch_in_range = (fetch_word < DEPTH_L);
  // Lane 3 - addr[1:0] sits at bit offset 8*(~addr[1:0]).
  assign lane_off       = {~addr_q[1:0], 3'b000};
  assign rd_byte        = mem[cmd_word[MEM_AW-1:0]][lane_off +: 8];

`ifdef LOADER_LOCK_EN
  assign wr_allow = ~cpu_rst_n_q;
`else
  assign wr_allow = 1'b1;
`endif

  assign wr_en = (state_q == S_EXEC) && (cmd_q == CMD_WR) && cmd_in_range && wr_allow;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one command per cmd_valid assertion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_ACK;
      S_ACK:   if (!cmd_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the command fields when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cmd_valid) begin
      cmd_q  <= cmd;
      addr_q <= address;
      din_q  <= data_in;
    end
  end

  // Read data register, updated only by read commands during EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else if (state_q == S_EXEC && cmd_q == CMD_RD) begin
      data_out_q <= cmd_in_range ? rd_byte : '0;
    end
  end

  // Byte-lane store write; reset at the same edge drops the write.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[cmd_word[MEM_AW-1:0]][lane_off +: 8] <= din_q;
    end
  end

  // Registered fetch port; old word is returned on a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst_n)              fetch_q <= '0;
    else if (fetch_in_range) fetch_q <= mem[fetch_word[MEM_AW-1:0]];
    else                     fetch_q <= NOP_INSN;
  end

  // Core reset gate: release only from IDLE, assert whenever start drops.
  always_ff @(posedge clk) begin
    if (!rst_n)                     cpu_rst_n_q <= 1'b0;
    else if (!start_signal)         cpu_rst_n_q <= 1'b0;
    else if (state_q == S_IDLE)     cpu_rst_n_q <= 1'b1;
  end

  assign cmd_done    = (state_q == S_ACK);
  assign data_out    = data_out_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign fetch_instr = fetch_q;

endmodule
